// File: rtl/mux_scan.sv
// Registered N-channel, W-bit selector with manual select and an automatic
// scan mode that dwells DWELL cycles on each channel before stepping on.
module mux_scan #(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int SW    = $clog2(N),
  parameter int DWELL = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] a,
  input  logic [SW-1:0]  s,
  input  logic           mode,
  input  logic           hold,
  output logic [W-1:0]   y,
  output logic [SW-1:0]  ch,
  output logic           ch_valid,
  output logic           sel_err
);

  localparam int CW  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SXW = SW + 1;
  // One extra bit so s can be compared against N even when N = 2**SW.
  localparam logic [SXW-1:0] NUM_CH   = SXW'(N);
  localparam logic [SW-1:0]  LAST_CH  = SW'(N - 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(DWELL - 1);

  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;

  always_comb begin
    ch_d  = ch_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (!mode) begin
      cnt_d = '0;
      if ({1'b0, s} < NUM_CH) ch_d = s;
      else                    err_d = 1'b1;
    end else if (!hold) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
        ch_d  = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Data follows the channel that will be current after this edge.
  always_comb begin
    y_d = '0;
    for (int i = 0; i < N; i++) begin
      if (ch_d == SW'(i)) y_d = a[i*W +: W];
    end
    vld_d = (ch_d != ch_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      ch_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      ch_q  <= ch_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  assign y        = y_q;
  assign ch       = ch_q;
  assign ch_valid = vld_q;
  assign sel_err  = err_q;

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N-channel, W-bit multiplexer with a manual-select mode and an automatic scan mode that steps through the channels on a programmable dwell count. It replaces the fixed 4:1 one-bit combinational selector in the combinational-logic experiments wherever a clocked, wider or auto-sequencing selector is needed, for example time-multiplexed display or probe routing. Outputs are registered, and a one-cycle pulse marks every channel change.

## Interface

- N, 4, number of input channels (N >= 2)
- W, 1, data width per channel
- SW, $clog2(N), select and channel-index width (derived; do not override)
- DWELL, 4, cycles spent on each channel in scan mode (DWELL >= 1)

- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- a  input  N*W  packed channel data; channel i occupies a[i*W +: W]
- s  input  SW  manual channel select
- mode  input  1  0 = manual, 1 = scan
- hold  input  1  scan mode only: freezes the dwell counter and the channel
- y  output  W  registered selected data
- ch  output  SW  registered index of the currently selected channel
- ch_valid  output  1  one-cycle pulse when ch changes value
- sel_err  output  1  registered flag: the manual select is out of range (s >= N)

## Operation

- Reset (asynchronous, rst_n = 0): y = 0, ch = 0, ch_valid = 0, sel_err = 0, dwell counter = 0.
  - The reset takes effect immediately, including mid-dwell or mid-scan.
  - The first edge after release behaves as a normal operating edge.
- Channel selection for the next edge (ch_next):
  - Manual (mode = 0):
    - ch_next = s when s < N.
    - When s >= N, ch_next = ch (hold) and sel_err_next = 1.
    - The dwell counter is held at 0.
  - Scan (mode = 1), hold = 0:
    - The dwell counter increments each cycle.
    - At DWELL-1 the counter returns to 0 and ch_next = (ch == N-1) ? 0 : ch+1.
    - Otherwise ch_next = ch.
  - Scan, hold = 1: the counter and ch are frozen. y keeps sampling a[ch], so data stays live.
  - sel_err_next = 0 in scan mode.
- Data path: on each edge, y <= a[ch_next*W +: W], so y always matches the updated ch.
- ch_valid <= (ch_next != ch). Reselecting the same channel gives no pulse.
- Mode transitions:
  - Manual to scan: scanning starts from the current ch with the counter at 0. The first advance occurs DWELL cycles later.
  - Scan to manual: takes effect on the first edge where mode = 0. The counter clears and ch follows s.
- DWELL = 1: ch advances every cycle in scan mode, and ch_valid stays high continuously.
- Arithmetic:
  - The counter width is $clog2(DWELL), minimum 1 bit.
  - The channel wrap is an explicit compare against N-1, not a natural overflow, so non-power-of-two N works.

## Timing

- Latency is one cycle for all inputs (a, s, mode, hold) to reach y, ch, ch_valid and sel_err.
- There is no combinational path from any input to any output.
- In scan mode with hold = 0, each channel is presented for exactly DWELL consecutive cycles. The full period is N*DWELL cycles.
- ch_valid is asserted in the same cycle that the new ch and y first appear.
- sel_err is asserted for every cycle in which the previous-edge manual s was out of range. It clears one edge after s returns in range or mode = 1.

## Test plan

- Reset then manual select, N=4, W=8, a = {8'h44, 8'h33, 8'h22, 8'h11}:
  - Stimulus: s = 0, 1, 2, 3 on successive cycles.
  - Required: y = 11, 22, 33, 44 and ch = 0..3, each one cycle later; ch_valid pulses on each change and not on a repeated s.
- Scan wrap, N=4, DWELL=4, mode = 1 from reset:
  - Required: ch = 0,0,0,0,1,1,1,1,2,… and returns to 0 after 16 cycles; ch_valid high exactly once per 4 cycles.
- Hold and live data in scan mode:
  - Stimulus: assert hold for 6 cycles while ch = 2, changing a[2] during the hold.
  - Required: ch stays 2 and the counter does not advance; y tracks the new a[2] with one-cycle latency; after hold drops, the remaining dwell resumes from the frozen count.
- Non-power-of-two range, N=3:
  - Manual: s = 3 gives sel_err = 1 next cycle, with ch and y unchanged; s = 1 then clears sel_err and gives ch = 1.
  - Scan: ch cycles 0→1→2→0.
- Mode switch:
  - Scan to manual at ch = 1 with s = 3 (N=4): ch = 3 next cycle, ch_valid = 1.
  - Back to scan: the first advance (3→0) occurs exactly DWELL cycles later.
- Asynchronous reset mid-scan:
  - Stimulus: drop rst_n between edges while ch = 3 and the counter = 2.
  - Required: y, ch, ch_valid and sel_err read 0 before the next clock edge; after release, scanning restarts at ch = 0 with a full dwell.
